// File: rtl/conv_10_mul_share_arb.sv
// ============================================================================
// Module   : conv_10_mul_share_arb
// Purpose  : Round-robin arbiter sharing one signed multiplier pipeline among
//            N_REQ requesters, with a tagged, backpressured response channel.
//            Define CONV_10_MUL_ARB_PRIO0_EN to give requester 0 strict priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_10_mul_share_arb #(
   parameter int N_REQ      = 4,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 24
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*din0_WIDTH-1:0]   req_din0,
   input  logic [N_REQ*din1_WIDTH-1:0]   req_din1,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [dout_WIDTH-1:0]         rsp_dout,
   output logic [$clog2(N_REQ)-1:0]      rsp_id
);

   localparam int ID_W = $clog2(N_REQ);

   logic [ID_W-1:0]        r_rr_ptr;
   logic [N_REQ-1:0]       w_grant;
   logic [ID_W-1:0]        w_gidx;
   logic                   w_found;
   logic                   w_stall;
   logic                   w_accept;
   logic [din0_WIDTH-1:0]  r_a;
   logic [din1_WIDTH-1:0]  r_b;
   logic [NUM_STAGE-1:0]   r_vld;
   logic [ID_W-1:0]        r_tag [NUM_STAGE];
   logic [dout_WIDTH-1:0]  w_a_ext;
   logic [dout_WIDTH-1:0]  w_b_ext;
   logic [dout_WIDTH-1:0]  w_prod;

   // (base + k) mod N_REQ for k in 0..N_REQ
   function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_found = 1'b0;
`ifdef CONV_10_MUL_ARB_PRIO0_EN
      if (req_valid[0]) begin
         w_found = 1'b1;
      end else
`endif
      begin
         for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[f_wrap(r_rr_ptr, k)]) begin
               w_found = 1'b1;
               w_gidx  = f_wrap(r_rr_ptr, k);
            end
         end
      end
      if (w_found) w_grant[w_gidx] = 1'b1;
   end

   assign w_stall   = r_vld[NUM_STAGE-1] & ~rsp_ready;
   assign req_ready = (ap_rst | w_stall) ? '0 : w_grant;
   assign w_accept  = w_found & ~w_stall;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
`ifdef CONV_10_MUL_ARB_PRIO0_EN
         // Priority grants to requester 0 leave the rotation untouched
         if (w_gidx != '0)
`endif
            r_rr_ptr <= f_wrap(w_gidx, 1);
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_vld <= '0;
         r_a   <= '0;
         r_b   <= '0;
         for (int i = 0; i < NUM_STAGE; i++) r_tag[i] <= '0;
      end else if (!w_stall) begin
         r_vld[0] <= w_accept;
         r_tag[0] <= w_gidx;
         for (int i = 1; i < NUM_STAGE; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
         if (w_accept) begin
            r_a <= req_din0[w_gidx*din0_WIDTH +: din0_WIDTH];
            r_b <= req_din1[w_gidx*din1_WIDTH +: din1_WIDTH];
         end
      end
   end

   // Sign-extending both operands to full width makes the modular product exact
   assign w_a_ext = {{din1_WIDTH{r_a[din0_WIDTH-1]}}, r_a};
   assign w_b_ext = {{din0_WIDTH{r_b[din1_WIDTH-1]}}, r_b};
   assign w_prod  = w_a_ext * w_b_ext;

   generate
      if (NUM_STAGE == 1) begin : g_comb_out
         assign rsp_dout = w_prod;
      end else begin : g_reg_out
         logic [dout_WIDTH-1:0] r_prod [NUM_STAGE-1];

         always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
               for (int i = 0; i < NUM_STAGE-1; i++) r_prod[i] <= '0;
            end else if (!w_stall) begin
               r_prod[0] <= w_prod;
               for (int i = 1; i < NUM_STAGE-1; i++) r_prod[i] <= r_prod[i-1];
            end
         end

         assign rsp_dout = r_prod[NUM_STAGE-2];
      end
   endgenerate

   assign rsp_valid = r_vld[NUM_STAGE-1];
   assign rsp_id    = r_tag[NUM_STAGE-1];

endmodule

`default_nettype wire

// File: tb/tb_conv_10_mul_share_arb.sv
// ============================================================================
// Module   : tb_conv_10_mul_share_arb
// Purpose  : Scoreboard bench for conv_10_mul_share_arb (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_10_mul_share_arb;

   localparam int N   = 4;
   localparam int W0  = 16;
   localparam int W1  = 8;
   localparam int WO  = 24;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*W0-1:0]   din0;
   logic [N*W1-1:0]   din1;
   logic [N-1:0]      req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WO-1:0]     rsp_dout;
   logic [IDW-1:0]    rsp_id;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WO+IDW-1:0] sb_q [$];
   logic [WO+IDW-1:0] sb_e;
   logic [WO-1:0]     hold_d;
   logic [IDW-1:0]    hold_id;

   conv_10_mul_share_arb dut (
      .ap_clk    (clk),
      .ap_rst    (rst),
      .req_valid (req_valid),
      .req_din0  (din0),
      .req_din1  (din1),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dout  (rsp_dout),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WO-1:0] f_model(input logic [W0-1:0] a, input logic [W1-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[WO-1:0];
   endfunction

   // Accepts push the modelled result; output handshakes pop and compare
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i])
               sb_q.push_back({IDW'(i), f_model(din0[i*W0 +: W0], din1[i*W1 +: W1])});
         if (rsp_valid && rsp_ready) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               sb_e = sb_q.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(sb_e[WO +: IDW]));
               chk("rsp_dout", 32'(rsp_dout), 32'(sb_e[WO-1:0]));
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [W0-1:0] a, input logic [W1-1:0] b);
      din0[i*W0 +: W0] = a;
      din1[i*W1 +: W1] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One cycle: sample grant, then refresh the granted requester's operands
   task automatic run_cycle(output logic [N-1:0] g);
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (g[i]) set_req(i, W0'($urandom), W1'($urandom));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1 chk("drain_empty", 32'(sb_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic [N-1:0] g;
      rst       = 1'b1;
      req_valid = '1;
      din0      = '0;
      din1      = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_dout", 32'(rsp_dout), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      req_valid = '0;

      // Single request with latency check
      set_req(2, 16'd300, -8'sd5);
      req_valid = 4'b0100;
      @(negedge clk) chk("single_grant", 32'(req_ready), 32'b0100);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk) chk("single_early", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("single_valid", 32'(rsp_valid), 1);
      chk("single_dout", 32'(rsp_dout), 32'h00FF_FA24);
      chk("single_id", 32'(rsp_id), 2);
      drain();

`ifndef CONV_10_MUL_ARB_PRIO0_EN
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, W0'($urandom), W1'($urandom));
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         run_cycle(g);
         chk("rr_grant", 32'(g), 32'(1 << (k % 4)));
      end
      req_valid = '0;
      drain();
`endif

      // Backpressure on a full pipeline
      req_valid = '1;
      repeat (4) run_cycle(g);
      rsp_ready = 1'b0;
      @(negedge clk);
      hold_d  = rsp_dout;
      hold_id = rsp_id;
      chk("stall_ready", 32'(req_ready), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_ready", 32'(req_ready), 0);
         chk("stall_dout", 32'(rsp_dout), 32'(hold_d));
         chk("stall_id", 32'(rsp_id), 32'(hold_id));
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      req_valid = '0;
      drain();

      // Arithmetic corners through requester 1
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       set_req(1, 16'h8000, 8'h80);
            1:       set_req(1, 16'h8000, 8'h7F);
            2:       set_req(1, 16'h7FFF, 8'hFF);
            default: set_req(1, 16'h0000, 8'h80);
         endcase
         req_valid = 4'b0010;
         @(negedge clk) chk("corner_grant", 32'(req_ready), 32'b0010);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      drain();

      // Reset between edges while two products are in flight
      set_req(1, 16'd1234, 8'd7);
      set_req(3, 16'd77, -8'sd3);
      req_valid = 4'b0010;
      @(negedge clk);
      @(posedge clk);
      #1 req_valid = 4'b1000;
      @(negedge clk);
      @(posedge clk);
      #1 req_valid = '0;
      #2 chk("pre_rst_valid", 32'(rsp_valid), 1);
      rst = 1'b1;
      sb_q.delete();
      #1 chk("async_rst_valid", 32'(rsp_valid), 0);
      chk("async_rst_ready", 32'(req_ready), 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) @(negedge clk) chk("no_stale", 32'(rsp_valid), 0);
      @(posedge clk);
      #1 req_valid = '1;
      @(negedge clk) chk("post_rst_grant", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1 req_valid = '0;
      drain();

`ifdef CONV_10_MUL_ARB_PRIO0_EN
      do_reset();
      req_valid = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         run_cycle(g);
         chk("prio0_grant", 32'(g), 32'b0001);
      end
      req_valid = 4'b1000;
      @(negedge clk) chk("prio0_release", 32'(req_ready), 32'b1000);
      @(posedge clk);
      #1 req_valid = '0;
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/conv_10_mul_share_arb.md
# conv_10_mul_share_arb

Round-robin arbiter and pipeline sequencer that shares one signed 16x8 multiplier among `N_REQ` requesters inside the `conv_10` layer. Each requester offers an operand pair with a valid/ready handshake. The block grants one request per cycle and pushes the operands through a `NUM_STAGE`-deep registered multiply pipeline. It returns the 24-bit product on a single tagged response channel that supports backpressure.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `NUM_STAGE`, 2: register stages from operand accept to `rsp_valid`; legal range 1..4.
- `din0_WIDTH`, 16: operand A width, signed.
- `din1_WIDTH`, 8: operand B width, signed.
- `dout_WIDTH`, 24: product width; must equal `din0_WIDTH+din1_WIDTH`.

Ports:
- `ap_clk`  in  1  clock; all logic is rising-edge triggered.
- `ap_rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_din0`  in  `N_REQ*din0_WIDTH`  packed A operands; requester i occupies slice i.
- `req_din1`  in  `N_REQ*din1_WIDTH`  packed B operands; requester i occupies slice i.
- `req_ready`  out  `N_REQ`  one-hot grant; request i is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts the product.
- `rsp_dout`  out  `dout_WIDTH`  signed product.
- `rsp_id`  out  `$clog2(N_REQ)`  index of the requester that owns `rsp_dout`.

## Operation
- Arbitration:
  - Round-robin pointer `rr_ptr` selects the first valid requester at or after `rr_ptr`, searching with modulo-`N_REQ` wrap.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and the stall signal. At most one bit is high, and only for a requester whose valid is high.
  - After an accept by requester g, `rr_ptr` becomes (g+1) mod `N_REQ`. With no accept, `rr_ptr` holds.
- Stall: `stall = rsp_valid & ~rsp_ready`.
  - While stalled, `req_ready` is all zero and every pipeline stage (valid, tag, data) holds.
  - There is no bubble collapsing.
- Pipeline:
  - Stage 1 registers the accepted operands together with the grant index and a valid bit.
  - Stages 2..`NUM_STAGE` shift the data, tag and valid bits forward.
  - The signed multiply `$signed(A)*$signed(B)` is computed combinationally from the stage-1 registers. Its result is captured into stage 2. When `NUM_STAGE`=1, the product feeds `rsp_dout` directly.
  - Output is the last stage.
- Arithmetic: the full-precision signed product, with no truncation or saturation. (-32768)*(-128) = +4194304 fits in 24 bits.
- Requester contract: a requester must hold its operands stable while `req_valid` is high and it has not yet been accepted. The arbiter never drops an accepted request.
- Reset, asynchronous, effective immediately:
  - `rr_ptr`=0.
  - All stage valid bits = 0, so `rsp_valid`=0.
  - `rsp_dout`=0, `rsp_id`=0.
  - `req_ready`=0 while `ap_rst` is high.
  - Reset during an in-flight product discards that product. No response is issued for it.

## Timing
- Accept at edge t produces `rsp_valid`=1 with the matching product from edge t+`NUM_STAGE`-1, i.e. visible in the `NUM_STAGE`th cycle after the accept cycle, provided no stall occurs.
- Each stall cycle adds exactly one cycle of latency to every in-flight item.
- Throughput is one accept per cycle when `rsp_ready` stays high.
- Simultaneous events:
  - `rsp_ready` rising in the same cycle as a new request means no stall that cycle. The request is accepted and the pipeline advances.
  - All requesters valid with no stall gives grants in order `rr_ptr`, `rr_ptr`+1, ... with wrap.
- `req_ready` depends combinationally on `rsp_ready`. This path is documented; consumers must not drive `rsp_ready` from `req_ready`.

## Configuration
- `CONV_10_MUL_ARB_PRIO0_EN` defined: requester 0 has strict priority. When `req_valid[0]` is high and there is no stall, it is granted regardless of `rr_ptr`, and `rr_ptr` is not updated. Requesters 1..`N_REQ`-1 round-robin among themselves when requester 0 is idle.
- Undefined: pure round-robin over all requesters, as described in Operation.

## Test plan
- Reset and single request: assert `ap_rst` for 3 cycles, then requester 2 sends A=300, B=-5 with `rsp_ready`=1. `req_ready`=4'b0100 in the accept cycle; `NUM_STAGE`=2 cycles later `rsp_valid`=1, `rsp_dout`=-1500, `rsp_id`=2.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles with `rsp_ready`=1. Grant order is 0,1,2,3,0,1,2,3, and the responses carry ids in the same order.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while the pipeline is full. `req_ready`=0, and `rsp_dout`/`rsp_id` stay constant. After release, products emerge in order with no loss and no duplication.
- Corner arithmetic: (-32768)*(-128) gives 4194304; (-32768)*127 gives -4161536; 32767*(-1) gives -32767; 0*(-128) gives 0.
- Reset mid-flight: accept 2 requests, then pulse `ap_rst` asynchronously between clock edges. `rsp_valid` drops immediately, no stale response appears afterwards, and the next grant goes to requester 0.
- With `CONV_10_MUL_ARB_PRIO0_EN`: requesters 0 and 3 are continuously valid. Requester 0 is granted every cycle and requester 3 is never granted. When requester 0 drops, requester 3 is granted the next cycle.
